// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs fields plus an immediate into a 32-bit word
// through a two-stage valid/ready pipeline and flags unrepresentable immediates.
package rv32_pkg;
  typedef enum logic [2:0] {
    Imm_I = 3'd0,
    Imm_S = 3'd1,
    Imm_B = 3'd2,
    Imm_U = 3'd3,
    Imm_J = 3'd4,
    Imm_R = 3'd5
  } ImmSel_t;
endpackage

module inst_encoder (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  rv32_pkg::ImmSel_t    imm_sel,
  input  logic [31:0]          imm,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          inst,
  output logic                 out_err,
  output logic [7:0]           err_cnt
);
  import rv32_pkg::*;

  logic        s1_valid_r;
  logic [31:0] s1_inst_r;
  logic        s1_err_r;
  logic        s2_adv_s;
  logic        in_xfer_s;
  logic        out_xfer_s;
  logic [32:0] enc_s;

  // True when every bit of the vector agrees with its top bit (fits as signed).
  function automatic logic all_eq21(input logic [20:0] v);
    return (&v) || (~|v);
  endfunction

  function automatic logic all_eq20(input logic [19:0] v);
    return (&v) || (~|v);
  endfunction

  function automatic logic all_eq12(input logic [11:0] v);
    return (&v) || (~|v);
  endfunction

  // Returns {err, inst}; on error the truncated encoding is still produced.
  function automatic logic [32:0] encode(
    input ImmSel_t     sel,
    input logic [31:0] im,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7
  );
    logic [31:0] w;
    logic        e;
    case (sel)
      Imm_I: begin
        w = {im[11:0], s1, f3, d, op};
        e = !all_eq21(im[31:11]);
      end
      Imm_S: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
        e = !all_eq21(im[31:11]);
      end
      Imm_B: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = !all_eq20(im[31:12]) || im[0];
      end
      Imm_U: begin
        w = {im[31:12], d, op};
        e = |im[11:0];
      end
      Imm_J: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = !all_eq12(im[31:20]) || im[0];
      end
      default: begin
        w = {f7, s2, s1, f3, d, op};
        e = 1'b0;
      end
    endcase
    return {e, w};
  endfunction

  // Handshake: output stage frees up when empty or drained this cycle.
  always_comb begin
    s2_adv_s   = !out_valid || out_ready;
    in_ready   = !s1_valid_r || s2_adv_s;
    in_xfer_s  = in_valid && in_ready;
    out_xfer_s = out_valid && out_ready;
    enc_s      = encode(imm_sel, imm, opcode, rd, rs1, rs2, funct3, funct7);
  end

  // Stage 1: encode and range-check on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_inst_r  <= 32'd0;
      s1_err_r   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_xfer_s) begin
        s1_inst_r <= enc_s[31:0];
        s1_err_r  <= enc_s[32];
      end else begin
        s1_inst_r <= s1_inst_r;
        s1_err_r  <= s1_err_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: output register, holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      inst      <= 32'd0;
      out_err   <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        inst    <= s1_inst_r;
        out_err <= s1_err_r;
      end else begin
        inst    <= inst;
        out_err <= out_err;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating count of errored output transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (out_xfer_s && out_err && (err_cnt != 8'd255)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed encodings, range errors,
// stall behaviour, round-trip decode, err_cnt saturation and mid-flight reset.
module tb_inst_encoder;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  ImmSel_t     imm_sel;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .inst(inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] decode(input ImmSel_t sel, input logic [31:0] i);
    case (sel)
      Imm_I:   return {{20{i[31]}}, i[31:20]};
      Imm_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      Imm_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      Imm_U:   return {i[31:12], 12'd0};
      Imm_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_fields(input ImmSel_t s, input logic [31:0] im, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                            input logic [2:0] f3, input logic [6:0] f7);
    imm_sel = s; imm = im; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7;
  endtask

  // One isolated transfer; returns the output at the negedge it first shows up.
  task automatic run1(input ImmSel_t s, input logic [31:0] im, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                      input logic [2:0] f3, input logic [6:0] f7,
                      output logic [31:0] got_inst, output logic got_err);
    int waited;
    @(negedge clk);
    set_fields(s, im, op, d, a, b, f3, f7);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency2", {31'd0, out_valid}, 32'd1);
    waited = 0;
    while (!out_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    got_inst = inst;
    got_err  = out_err;
  endtask

  logic [31:0] gi;
  logic        ge;
  logic [31:0] r;
  logic [31:0] legal;
  ImmSel_t     sel;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] prev_inst;
  logic        prev_stall;
  logic        seen_not_ready;
  int          idx;
  int          seen_out;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(Imm_R, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    // Hand-encoded legal instructions.
    run1(Imm_I, 32'hFFFFF800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, gi, ge);
    chk("addi_inst", gi, 32'h80010093); chk("addi_err", {31'd0, ge}, 32'd0);
    run1(Imm_S, 32'hFFFFFFFC, 7'h23, 5'd0, 5'd3, 5'd5, 3'd2, 7'd0, gi, ge);
    chk("sw_inst", gi, 32'hFE51AE23); chk("sw_err", {31'd0, ge}, 32'd0);
    run1(Imm_B, 32'h00000008, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, gi, ge);
    chk("beq_inst", gi, 32'h00208463); chk("beq_err", {31'd0, ge}, 32'd0);
    run1(Imm_J, 32'h00000800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, gi, ge);
    chk("jal_inst", gi, 32'h001000EF); chk("jal_err", {31'd0, ge}, 32'd0);
    run1(Imm_U, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, gi, ge);
    chk("lui_inst", gi, 32'h123452B7); chk("lui_err", {31'd0, ge}, 32'd0);
    run1(Imm_R, 32'hFFFFFFFF, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, gi, ge);
    chk("sub_inst", gi, 32'h402081B3); chk("sub_err", {31'd0, ge}, 32'd0);
    @(negedge clk);
    chk("err_cnt_clean", {24'd0, err_cnt}, 32'd0);

    // Range errors and boundaries.
    run1(Imm_B, 32'h00000003, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, gi, ge);
    chk("b_odd_err", {31'd0, ge}, 32'd1);
    @(negedge clk);
    chk("err_cnt_1", {24'd0, err_cnt}, 32'd1);
    run1(Imm_B, 32'h00001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, gi, ge);
    chk("b_range_err", {31'd0, ge}, 32'd1);
    run1(Imm_I, 32'h000007FF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, gi, ge);
    chk("i_max_ok", {31'd0, ge}, 32'd0); chk("i_max_inst", gi, 32'h7FF10093);
    run1(Imm_I, 32'h00000800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, gi, ge);
    chk("i_over_err", {31'd0, ge}, 32'd1);
    run1(Imm_U, 32'h00000001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, gi, ge);
    chk("u_low_err", {31'd0, ge}, 32'd1);
    run1(Imm_J, 32'h00000801, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, gi, ge);
    chk("j_odd_err", {31'd0, ge}, 32'd1);
    run1(Imm_S, 32'hFFFFF7FF, 7'h23, 5'd0, 5'd3, 5'd5, 3'd2, 7'd0, gi, ge);
    chk("s_under_err", {31'd0, ge}, 32'd1);
    @(negedge clk);
    chk("err_cnt_6", {24'd0, err_cnt}, 32'd6);

    // Four back-to-back inputs with a 3-cycle consumer stall.
    seen_not_ready = 1'b0; prev_stall = 1'b0; prev_inst = 32'd0; idx = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back({k[7:0], 4'd0, 5'd2, 3'd0, 5'd1, 7'h13});
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (idx < 4) begin
        set_fields(Imm_I, {24'd0, idx[3:0], 4'd0}, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) chk("stall_stable", inst, prev_inst);
      if (in_valid && !in_ready) seen_not_ready = 1'b1;
      if (out_valid && out_ready) got_q.push_back(inst);
      if (in_valid && in_ready) idx++;
      prev_stall = out_valid && !out_ready;
      prev_inst  = inst;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_in_ready_drop", {31'd0, seen_not_ready}, 32'd1);
    chk("stall_count", got_q.size(), 32'd4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) chk("stall_order", got_q[k], exp_q[k]);

    // Constrained-legal random immediates must round-trip.
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      case (k % 5)
        0: begin sel = Imm_I; legal = {{20{r[11]}}, r[11:0]}; end
        1: begin sel = Imm_S; legal = {{20{r[11]}}, r[11:0]}; end
        2: begin sel = Imm_B; legal = {{19{r[12]}}, r[12:1], 1'b0}; end
        3: begin sel = Imm_U; legal = {r[31:12], 12'd0}; end
        default: begin sel = Imm_J; legal = {{11{r[20]}}, r[20:1], 1'b0}; end
      endcase
      run1(sel, legal, 7'($urandom_range(127, 0)), 5'($urandom_range(31, 0)),
           5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), 3'($urandom_range(7, 0)),
           7'd0, gi, ge);
      chk("rt_err", {31'd0, ge}, 32'd0);
      chk("rt_imm", decode(sel, gi), legal);
      chk("rt_opcode", {25'd0, gi[6:0]}, {25'd0, opcode});
    end

    // 300 errored transfers at full throughput saturate err_cnt.
    @(negedge clk);
    out_ready = 1'b1;
    set_fields(Imm_B, 32'h00000003, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0);
    in_valid = 1'b1;
    seen_out = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid) seen_out++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) seen_out++;
    end
    chk("throughput", seen_out, 32'd300);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Reset with both stages full.
    @(negedge clk);
    out_ready = 1'b0;
    set_fields(Imm_I, 32'h00000010, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_before_rst", {30'd0, out_valid, in_ready}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_mid_inst", inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen_out = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen_out++;
    end
    chk("no_out_after_rst", seen_out, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
  clk  in  1  single clock; all state on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  in_valid  in  1  request valid.
  in_ready  out  1  request accepted when in_valid && in_ready.
  imm_sel  in  rv32_pkg::ImmSel_t  format select (Imm_I/S/B/U/J; any other value = R-type).
  imm  in  32  byte-offset/immediate value to encode.
  opcode  in  7  opcode field.
  rd  in  5  destination register.
  rs1  in  5  source register 1.
  rs2  in  5  source register 2.
  funct3  in  3  funct3 field.
  funct7  in  7  funct7 field (R-type only).
  out_valid  out  1  encoded instruction valid.
  out_ready  in  1  consumer accepts when out_valid && out_ready.
  inst  out  32  encoded RV32 instruction.
  out_err  out  1  immediate not representable in the selected format.
  err_cnt  out  8  saturating count of errored output transfers.
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL be a two-stage valid/ready pipeline (S1 encode + range check, S2 output register); latency 2 cycles from input transfer to out_valid with out_ready held high.
REQ-004 SHALL sustain one transfer per cycle when out_ready is continuously high.
REQ-005 S2 SHALL advance when !out_valid || out_ready; S1 SHALL advance into S2 when S1 valid and S2 advances; in_ready SHALL be !S1_valid || S2-advance (combinational from out_ready, no skid buffer).
REQ-006 inst, out_err SHALL hold stable while out_valid && !out_ready.
REQ-007 Field placement, common: inst[6:0]=opcode; inst[11:7]=rd and inst[14:12]=funct3 where the format has them; inst[19:15]=rs1, inst[24:20]=rs2 where present.
REQ-008 Imm_I: inst[31:20]=imm[11:0]; rd, funct3, rs1 placed; error iff imm[31:11] not all equal.
REQ-009 Imm_S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; funct3, rs1, rs2 placed; error iff imm[31:11] not all equal.
REQ-010 Imm_B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]; funct3, rs1, rs2 placed; error iff imm[31:12] not all equal or imm[0]=1.
REQ-011 Imm_U: inst[31:12]=imm[31:12]; rd placed; error iff imm[11:0]!=0.
REQ-012 Imm_J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]; rd placed; error iff imm[31:20] not all equal or imm[0]=1.
REQ-013 Other imm_sel: R-type, inst[31:25]=funct7, rd/funct3/rs1/rs2 placed, imm ignored, out_err=0.
REQ-014 On error the instruction SHALL still be emitted with truncated bits as above and out_err=1.
REQ-015 When out_err=0, sign-extension/decoding of inst[31:7] per the same format SHALL reproduce imm exactly (round-trip property).
REQ-016 err_cnt SHALL increment by 1 on each output transfer with out_err=1, saturating at 255.

Reset
REQ-017 rst_n low SHALL asynchronously clear both stage valids, out_valid=0, inst=0, out_err=0, err_cnt=0; in_ready=1 while in reset.
REQ-018 Reset mid-operation SHALL discard in-flight instructions; no output transfer after reset release until a new input transfer plus 2 cycles.

Verification
REQ-019 Imm_I, imm=0xFFFFF800 (-2048), rs1=2, rd=1, funct3=0, opcode=0x13 -> inst=0x80010093, out_err=0, 2 cycles later.
REQ-020 Imm_B, imm=0x00000003 -> out_err=1, err_cnt 0->1; imm=0x00001000 -> out_err=1 (out of range).
REQ-021 Imm_U, imm=0x12345000, rd=5, opcode=0x37 -> inst=0x123452B7, out_err=0.
REQ-022 Back-to-back 4 inputs with out_ready low 3 cycles mid-stream -> in_ready drops, no loss/duplication, order preserved, inst stable while stalled.
REQ-023 Random constrained-legal imm for all formats -> decode of inst[31:7] equals imm; 300 errored transfers -> err_cnt=255.
REQ-024 Assert rst_n low with both stages full -> out_valid=0 immediately, err_cnt=0, no output after release.
